seq_detect_prog: RTL and testbench

SEQ_DETECT_PROG -- requirements
Module: seq_detect_prog

---
 rtl/seq_detect_prog.sv | 67 ++++++
 tb/tb_seq_detect_prog.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/seq_detect_prog.sv
// seq_detect_prog: programmable serial sequence detector with overlap control and saturating match count
module seq_detect_prog #(
    parameter int MAX_LEN = 8,
    parameter int CNT_W = 16,
    localparam int LEN_W = $clog2(MAX_LEN + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               xin,
    input  logic               cfg_load,
    input  logic [MAX_LEN-1:0] pattern,
    input  logic [LEN_W-1:0]   pat_len,
    input  logic               overlap,
    output logic               zout,
    output logic               match_q,
    output logic [CNT_W-1:0]   match_cnt,
    output logic [LEN_W-1:0]   fill,
    output logic               cfg_err
);
    logic [MAX_LEN-1:0] hist_q, hist_d, pat_q, pat_d;
    logic [LEN_W-1:0]   fill_q, fill_d, len_q, len_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [MAX_LEN:0]   mask;
    logic               hit;

    assign cfg_err   = (len_q < LEN_W'(2)) || (len_q > LEN_W'(MAX_LEN));
    assign fill      = fill_q;
    assign match_cnt = cnt_q;

    // Mealy match: low cfg_len bits of {history, xin} against the pattern, once enough bits are valid
    always_comb begin
        mask = ~({(MAX_LEN + 1){1'b1}} << len_q);
        hit  = ((({hist_q, xin} ^ {1'b0, pat_q}) & mask) == '0);
        zout = en && !cfg_load && !cfg_err && hit &&
               (({1'b0, fill_q} + (LEN_W + 1)'(1)) >= {1'b0, len_q});
    end

    // Next state: a config load wipes history; non-overlapping matches restart the fill count
    always_comb begin
        pat_d  = cfg_load ? pattern : pat_q;
        len_d  = cfg_load ? pat_len : len_q;
        hist_d = cfg_load ? '0 : en ? {hist_q[MAX_LEN-2:0], xin} : hist_q;
        fill_d = cfg_load ? '0 : !en ? fill_q : (zout && !overlap) ? '0 :
                 (fill_q == LEN_W'(MAX_LEN)) ? fill_q : fill_q + LEN_W'(1);
        cnt_d  = (zout && cnt_q != '1) ? cnt_q + CNT_W'(1) : cnt_q;
    end

    // State registers with active-low synchronous reset taking priority over everything
    always_ff @(posedge clk) begin
        if (!rst) begin
            hist_q  <= '0;
            fill_q  <= '0;
            pat_q   <= '0;
            len_q   <= '0;
            cnt_q   <= '0;
            match_q <= 1'b0;
        end else begin
            hist_q  <= hist_d;
            fill_q  <= fill_d;
            pat_q   <= pat_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            match_q <= zout;
        end
    end
endmodule

// File: tb/tb_seq_detect_prog.sv
// tb_seq_detect_prog: directed scenarios plus random stimulus against a bit-queue reference model
module tb_seq_detect_prog;
    logic        clk = 0, rst = 0, en = 0, xin = 0, cfg_load = 0, overlap = 1;
    logic [7:0]  pattern = 0;
    logic [3:0]  pat_len = 0;
    logic        zout, match_q, cfg_err, z2, mq2, err2;
    logic [15:0] match_cnt;
    logic [1:0]  cnt2;
    logic [3:0]  fill, fill2;
    int          n_tests = 0, n_fail = 0;

    bit          m_q[$];
    int          m_fill = 0, m_cnt = 0, m_cnt2 = 0, m_len = 0;
    bit [7:0]    m_pat = 0;
    bit          m_prev = 0;

    always #5 clk = ~clk;

    seq_detect_prog #(.MAX_LEN(8), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .en(en), .xin(xin), .cfg_load(cfg_load), .pattern(pattern),
        .pat_len(pat_len), .overlap(overlap), .zout(zout), .match_q(match_q),
        .match_cnt(match_cnt), .fill(fill), .cfg_err(cfg_err));

    seq_detect_prog #(.MAX_LEN(8), .CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .en(en), .xin(xin), .cfg_load(cfg_load), .pattern(pattern),
        .pat_len(pat_len), .overlap(overlap), .zout(z2), .match_q(mq2),
        .match_cnt(cnt2), .fill(fill2), .cfg_err(err2));

    task automatic chk(input string tag, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit model_z();
        bit w;
        if (!en || cfg_load || m_len < 2 || m_len > 8 || m_fill + 1 < m_len) return 0;
        for (int k = 0; k < m_len; k++) begin
            w = (k == 0) ? xin : (m_q.size() >= k ? m_q[m_q.size() - k] : 1'b0);
            if (w != m_pat[k]) return 0;
        end
        return 1;
    endfunction

    task automatic step(input bit r, input bit e, input bit x, input bit ld);
        bit z;
        rst = r; en = e; xin = x; cfg_load = ld;
        #1;
        z = model_z();
        chk("zout", zout, z);
        chk("zout_w2", z2, z);
        @(posedge clk); #1;
        if (!r) begin
            m_q.delete(); m_fill = 0; m_cnt = 0; m_cnt2 = 0; m_pat = 0; m_len = 0; m_prev = 0;
        end else begin
            m_prev = z;
            if (z) begin
                if (m_cnt < 65535) m_cnt++;
                if (m_cnt2 < 3) m_cnt2++;
            end
            if (ld) begin
                m_pat = pattern; m_len = pat_len; m_q.delete(); m_fill = 0;
            end else if (e) begin
                m_q.push_back(x);
                if (m_q.size() > 16) void'(m_q.pop_front());
                m_fill = (z && !overlap) ? 0 : (m_fill < 8 ? m_fill + 1 : 8);
            end
        end
        chk("match_q", match_q, m_prev);
        chk("match_cnt", match_cnt, m_cnt);
        chk("match_cnt_w2", cnt2, m_cnt2);
        chk("fill", fill, m_fill);
        chk("cfg_err", cfg_err, (m_len < 2 || m_len > 8) ? 1 : 0);
    endtask

    task automatic do_reset();
        step(0, 0, 0, 0);
    endtask

    task automatic load(input bit [7:0] p, input int l);
        pattern = p; pat_len = 4'(l);
        step(1, 0, 0, 1);
    endtask

    task automatic stream(input int n, input bit [31:0] bits);
        for (int i = n - 1; i >= 0; i--) step(1, 1, bits[i], 0);
    endtask

    initial begin
        rst = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_cnt", match_cnt, 0);
        chk("rst_fill", fill, 0);
        chk("rst_cfg_err", cfg_err, 1);
        chk("rst_match_q", match_q, 0);

        // overlapping 1011 on 1011011
        overlap = 1; do_reset(); load(8'b0000_1011, 4);
        stream(7, 32'b1011011);
        chk("s_ovl_cnt", match_cnt, 2);

        // non-overlapping: only the first match counts, fill restarts
        overlap = 0; do_reset(); load(8'b0000_1011, 4);
        stream(4, 32'b1011);
        chk("s_novl_fill", fill, 0);
        stream(3, 32'b011);
        chk("s_novl_cnt", match_cnt, 1);

        // en gap holds history
        overlap = 1; do_reset(); load(8'b0000_1011, 4);
        stream(3, 32'b101);
        repeat (3) step(1, 0, 1, 0);
        chk("s_gap_fill", fill, 3);
        step(1, 1, 1, 0);
        chk("s_gap_cnt", match_cnt, 1);

        // illegal configurations
        do_reset();
        stream(4, 32'b1111);
        chk("s_cfg_cnt0", match_cnt, 0);
        load(8'b0000_0000, 9);
        chk("s_cfg_len9", cfg_err, 1);
        load(8'b0000_0111, 3);
        chk("s_cfg_ok", cfg_err, 0);
        stream(3, 32'b111);
        chk("s_cfg_cnt1", match_cnt, 1);

        // saturation in the 2-bit counter
        overlap = 1; do_reset(); load(8'b0000_0011, 2);
        stream(6, 32'b111111);
        chk("s_sat_cnt2", cnt2, 3);
        chk("s_sat_cnt16", match_cnt, 5);

        // reset mid-sequence discards history
        do_reset(); load(8'b0000_1011, 4);
        stream(3, 32'b101);
        step(0, 0, 0, 0);
        step(1, 1, 1, 0);
        chk("s_rst_fill", fill, 1);
        chk("s_rst_cnt", match_cnt, 0);

        // load coinciding with a would-be match takes priority
        do_reset(); load(8'b0000_0011, 2);
        step(1, 1, 1, 0);
        pattern = 8'b0000_0011; pat_len = 2;
        step(1, 1, 1, 1);
        chk("s_ldpri_cnt", match_cnt, 0);

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            int r = $urandom_range(0, 99);
            overlap = ($urandom_range(0, 9) != 0) ? overlap : ~overlap;
            if (r == 0) step(0, $urandom_range(0, 1), $urandom_range(0, 1), 0);
            else if (r < 3) begin
                pattern = 8'($urandom);
                pat_len = 4'($urandom_range(0, 9) < 8 ? $urandom_range(2, 4) : $urandom_range(0, 10));
                step(1, $urandom_range(0, 1), $urandom_range(0, 1), 1);
            end else step(1, $urandom_range(0, 9) < 8, $urandom_range(0, 1), 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
